// File: rtl/axis_source.sv
// axis_source: AXI-stream packet generator.
// A start command produces one packet of length+1 items. The items carry an
// incrementing sequence from a latched base value, and last marks the final
// item. An optional idle gap can follow every non-final handshake. Every
// output is registered, so no combinational path runs from ready to an output.
module axis_source #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  base,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic [COUNT_WIDTH-1:0] gap,
  input  logic                   ready,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   valid,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 state_q,   state_d;
  logic [DATA_WIDTH-1:0]  data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   last_q,    last_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic [COUNT_WIDTH-1:0] idx_q,     idx_d;
  logic [COUNT_WIDTH-1:0] len_q,     len_d;
  logic [COUNT_WIDTH-1:0] gap_cfg_q, gap_cfg_d;
  logic [COUNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [COUNT_WIDTH-1:0] idx_nxt;

  // The index compare stays on COUNT_WIDTH bits, so length = all-ones yields 2^COUNT_WIDTH items.
  assign idx_nxt = idx_q + 1'b1;

  // Next-state and next-output logic for the IDLE/SEND/GAP sequencer.
  always_comb begin
    // NOTE: every variable gets a default first, so a path that does not assign it cannot infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_cfg_d = gap_cfg_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d    = base;
          valid_d   = 1'b1;
          last_d    = (length == '0);
          busy_d    = 1'b1;
          idx_d     = '0;
          len_d     = length;
          gap_cfg_d = gap;
          state_d   = SEND;
        end
      end

      SEND: begin
        // valid is high throughout SEND, so ready alone signals a handshake.
        if (ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            data_d = data_q + 1'b1;
            idx_d  = idx_nxt;
            last_d = (idx_nxt == len_q);
            if (gap_cfg_q != '0) begin
              valid_d   = 1'b0;
              gap_cnt_d = gap_cfg_q;
              state_d   = GAP;
            end
          end
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == COUNT_WIDTH'(1)) begin
          valid_d = 1'b1;
          state_d = SEND;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: registers take non-blocking assignments, so every flop samples the same pre-edge values.
    if (!resetn) begin
      state_q   <= IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      gap_cfg_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_cfg_q <= gap_cfg_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // A stalled item must stay unchanged until the sink accepts it.
  a_stable_on_stall: assert property (@(posedge clock) disable iff (!resetn)
    (valid_q && !ready) |=> ($stable(data_q) && $stable(last_q)));

  // valid can only be high while a packet is in progress.
  a_valid_busy: assert property (@(posedge clock) disable iff (!resetn)
    valid_q |-> busy_q);

  // The done pulse follows the final handshake, when no item is being offered.
  a_done_idle: assert property (@(posedge clock) disable iff (!resetn)
    done_q |-> !valid_q);

endmodule

// File: tb/tb_axis_source.sv
// Directed testbench for axis_source. A scoreboard queue is loaded with the
// expected items whenever a start is driven, and each handshake pops one item
// and compares it.
module tb_axis_source;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] base;
  logic [3:0] length;
  logic [3:0] gap;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } item_t;

  item_t       sb_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned vcnt     = 0;

  axis_source #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .base   (base),
    .length (length),
    .gap    (gap),
    .ready  (ready),
    .data   (data),
    .valid  (valid),
    .last   (last),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set for the coming edge, so valid&&ready here means a handshake occurs at that edge.
  task automatic cycle();
    item_t exp_item;
    if (valid) vcnt++;
    if (valid && ready && resetn) begin
      check("sb_nonempty", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_item = sb_q.pop_front();
        check("item_data", data, exp_item.data);
        check("item_last", last, exp_item.last);
      end
    end
    @(negedge clock);
  endtask

  // Drive a start for one edge, load the expected items, then scramble the config inputs.
  task automatic start_pkt(input logic [7:0] b, input logic [3:0] l, input logic [3:0] g);
    item_t it;
    base   = b;
    length = l;
    gap    = g;
    start  = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      it.data = b + i[7:0];
      it.last = (i == int'(l));
      sb_q.push_back(it);
    end
    cycle();
    start  = 1'b0;
    base   = ~b;
    length = ~l;
    gap    = ~g;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      cycle();
    end
    check(tag, done, 1);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    logic [6:0] pattern;
    resetn = 1'b0;
    start  = 1'b0;
    base   = '0;
    length = '0;
    gap    = '0;
    ready  = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", valid, 0);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_last",  last,  0);
    check("rst_data",  data,  0);
    resetn = 1'b1;
    cycle();
    check("idle_valid", valid, 0);

    // 1: back-to-back with data wrap FE,FF,00,01
    ready = 1'b1;
    start_pkt(8'hFE, 4'd3, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", valid, 1);
      check("t1_busy",  busy,  1);
      check("t1_done",  done,  0);
      cycle();
    end
    check("t1_done_pulse", done,  1);
    check("t1_busy_low",   busy,  0);
    check("t1_valid_low",  valid, 0);
    check("t1_sb_empty",   sb_q.size(), 0);
    cycle();
    check("t1_done_clear", done, 0);

    // 2: stall on the second item for three cycles
    vcnt = 0;
    start_pkt(8'h10, 4'd2, 4'd0);
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_valid", valid, 1);
      check("t2_stall_data",  data,  8'h11);
      check("t2_stall_last",  last,  0);
      cycle();
    end
    ready = 1'b1;
    wait_done("t2_done");
    check("t2_valid_cycles", vcnt, 6);

    // 3: gap of two idle cycles between items
    start_pkt(8'h20, 4'd2, 4'd2);
    for (int i = 0; i < 7; i++) begin
      pattern[6-i] = valid;
      cycle();
    end
    check("t3_valid_pattern", pattern, 7'b1001001);
    check("t3_done", done, 1);
    check("t3_sb_empty", sb_q.size(), 0);

    // 4: single-item packet
    start_pkt(8'h55, 4'd0, 4'd0);
    check("t4_valid", valid, 1);
    check("t4_last",  last,  1);
    check("t4_data",  data,  8'h55);
    check("t4_busy",  busy,  1);
    cycle();
    check("t4_done",  done,  1);
    check("t4_busy_low", busy, 0);

    // 5: start mid-packet is ignored; start in the done cycle is accepted
    start_pkt(8'h30, 4'd3, 4'd1);
    start = 1'b1;
    base  = 8'h99;
    length = 4'd0;
    gap   = 4'd0;
    cycle();
    cycle();
    start = 1'b0;
    wait_done("t5_done");
    start_pkt(8'hA0, 4'd1, 4'd0);
    check("t5_restart_data",  data,  8'hA0);
    check("t5_restart_valid", valid, 1);
    check("t5_restart_done",  done,  0);
    wait_done("t5_restart_done_pulse");

    // 6: reset during the third item aborts the packet with no done pulse
    start_pkt(8'h40, 4'd7, 4'd0);
    cycle();
    cycle();
    check("t6_third_data", data, 8'h42);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    sb_q.delete();
    check("t6_valid", valid, 0);
    check("t6_busy",  busy,  0);
    check("t6_done",  done,  0);
    check("t6_data",  data,  0);
    check("t6_last",  last,  0);
    for (int i = 0; i < 12; i++) begin
      check("t6_no_done",  done,  0);
      check("t6_no_valid", valid, 0);
      cycle();
    end
    start_pkt(8'h77, 4'd1, 4'd0);
    check("t6_fresh_data", data, 8'h77);
    wait_done("t6_fresh_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_source.md
Name: axis_source

Overview:
- AXI-stream packet generator: the driving end of the valid/ready stream our bus monitor observes.
- On a start command it emits one packet of length+1 items. Item data is an incrementing sequence starting at a latched base value. last is asserted on the final item.
- An optional idle gap can be inserted between items.
- Used as a stimulus source for formal and hardware test harnesses.

Parameters:
DATA_WIDTH, 8, width of data and base
COUNT_WIDTH, 4, width of length, gap and the internal item/gap counters

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  reset, synchronous, active-low
start  input  1  request a packet; sampled only when busy=0
base  input  DATA_WIDTH  data of first item, latched on accepted start
length  input  COUNT_WIDTH  packet has length+1 items, latched on accepted start
gap  input  COUNT_WIDTH  idle cycles after each non-final handshake, latched on accepted start
ready  input  1  stream ready from sink
data  output  DATA_WIDTH  stream data (registered)
valid  output  1  stream valid (registered)
last  output  1  final item of packet (registered)
busy  output  1  packet in progress (registered)
done  output  1  one-cycle pulse after final handshake (registered)

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-low (resetn).
- All outputs are registered. No combinational path from ready to any output.
- Reset (resetn=0 at a clock edge):
  - state=IDLE; valid=0, last=0, busy=0, done=0, data=0; counters=0.
  - Reset applies mid-packet as well: the packet is aborted and no done pulse is generated.
- States: IDLE, SEND, GAP.
- IDLE:
  - done is cleared every cycle unless set by a final handshake.
  - If start=1: latch base/length/gap, set data<=base, valid<=1, last<=(length==0), busy<=1, item index<=0, go to SEND.
  - The first item is therefore valid 1 cycle after start.
- SEND:
  - valid=1. data and last are held stable until valid&&ready (AXIS rule). valid never drops without a handshake.
  - Handshake with last=1: valid<=0, last<=0, busy<=0, done<=1 (one cycle), go to IDLE.
  - Handshake with last=0 and gap==0: data<=data+1, index<=index+1, last<=(index+1==length), stay in SEND. Back-to-back: one item per cycle with ready held high.
  - Handshake with last=0 and gap!=0: valid<=0, gap counter<=gap, data<=data+1, index<=index+1, last<=(index+1==length), go to GAP.
- GAP:
  - valid=0 for exactly gap cycles; the gap counter decrements each cycle.
  - When the counter is 1: valid<=1, go to SEND.
  - ready is ignored in GAP.
- Arithmetic and sampling:
  - data increments modulo 2^DATA_WIDTH (FE->FF->00).
  - Index comparison is on COUNT_WIDTH bits. length=2^COUNT_WIDTH-1 gives 2^COUNT_WIDTH items.
  - start, base, length and gap are ignored while busy=1. Input changes mid-packet have no effect.
- done / restart timing:
  - In the cycle done=1 the state is IDLE and busy=0, so a start in that cycle is accepted.
  - The new packet's first item is then valid on the next cycle, and done returns to 0.
- Formal: assert stability of data/last while valid&&!ready. Assert valid implies busy. Assert done implies !valid.

Test Plan:
1. base=8'hFE, length=3, gap=0, ready=1 constantly, pulse start -> valid high 4 consecutive cycles; data FE,FF,00,01; last only on 01; busy high for those 4 cycles; done=1 the cycle after the 01 handshake.
2. base=8'h10, length=2, gap=0; ready low for 3 cycles on the second item -> data=11, valid=1, last=0 held unchanged for 3 cycles; items 10,11,12 each transfer exactly once; total packet 6 cycles.
3. base=8'h20, length=2, gap=2, ready=1 -> valid pattern 1,0,0,1,0,0,1; data 20,21,22; last with 22; done after 22.
4. length=0, base=8'h55 -> single item 55 with last=1 on the first valid cycle; done on the next cycle; busy high 1 cycle.
5. start pulsed mid-packet with different base -> ignored, sequence unchanged. start asserted in the done cycle with base=8'hA0 -> data=A0, valid=1 the following cycle.
6. resetn=0 for one edge during the third item of a length=7 packet -> next cycle valid=0, busy=0, done=0, data=0, last=0; no done pulse ever follows; a later start produces a fresh packet from its base.
